multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview: Main control FSM that sequences a shared-memory multicycle RV32I datapath. It decodes opcode and funct fields, then drives all datapath selects and write enables one state per cycle. It stalls on a memory ready handshake and counts retired instructions. It sits beside the register file, ALU and unified instruction/data memory inside the processor top.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter InstRet.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  7  instruction opcode, Instr[6:0]
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory has completed the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address: 0 = PC, 1 = Result
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction and OldPC register enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 A (rs1), 11 zero
ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  output  1  register file write enable
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalInstr  output  1  one-cycle pulse on unsupported opcode
State  output  4  current state, for debug
InstRet  output  CNT_WIDTH  retired-instruction count

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, LUI 11. Codes 12-15 go to FETCH.
- Reset low: State = FETCH and InstRet = 0, applied immediately and asynchronously. PCWrite, IRWrite, RegWrite, MemWrite and IllegalInstr are forced to 0 while reset is low. A reset in any state, including a stalled memory state, aborts the instruction with no further writes.
- Outputs are Moore (decoded from State) except:
  - ImmSrc is decoded from op.
  - ALUControl in EXECUTER and EXECUTEI is decoded from funct3/funct7b5.
  - PCWrite in BEQ depends on Zero.
  - Write enables in memory states are gated by MemReady.
- Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite = PCWrite = MemReady. Go to DECODE when MemReady=1, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target captured into ALUOut). Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - 0110111 -> LUI
  - any other op -> FETCH with IllegalInstr=1 for this cycle only; InstRet is unchanged.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay while MemReady=0, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held for every cycle in this state. Go to FETCH when MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00. EXECUTEI: ALUSrcA=10, ALUSrcB=01. Both go to ALUWB.
- Function decode (funct3): 000 -> add, or sub when R-type and funct7b5=1; 010 -> slt; 110 -> or; 111 -> and; any other -> add.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Go to FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01, add. Go to ALUWB.
- InstRet increments by 1 on each of these transitions: MEMWB->FETCH, ALUWB->FETCH, MEMWRITE->FETCH (MemReady=1), BEQ->FETCH. It wraps modulo 2^CNT_WIDTH.
- Cycle counts with MemReady tied to 1:
  - lw: 5
  - sw, R-type, I-type, jal, lui: 4
  - beq: 3
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Assert reset while MEMREAD is stalled with MemReady=0 -> State=0 and InstRet=0 immediately; RegWrite and MemWrite stay 0; after release, FETCH proceeds normally.
- addi x1,x0,1 (0x00100093), MemReady=1 -> states 0,1,8,7,0; RegWrite=1 only in state 7; ALUControl=000; ImmSrc=000; InstRet=1.
- lw with MemReady=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with ResultSrc=01 and RegWrite=1; 8 cycles total; InstRet increments once.
- beq with Zero=1 -> PCWrite=1 in state 10; repeat with Zero=0 -> PCWrite=0; both take 3 cycles.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in state 6. lui x4,0x22222 -> states 0,1,11,7 with ALUSrcA=11, ImmSrc=100.
- op=1111111 -> IllegalInstr high exactly one cycle in DECODE; next state 0; RegWrite, MemWrite and PCWrite never asserted; InstRet unchanged.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Main control FSM for a shared-memory multicycle RV32I datapath. One state
//   per cycle drives the datapath selects and write enables; memory accesses
//   stall on MemReady, and retired instructions are counted in InstRet.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset (0 = in reset)
//   op            instruction opcode, Instr[6:0]
//   funct3        Instr[14:12]
//   funct7b5      Instr[30]
//   Zero          ALU zero flag (beq)
//   MemReady      memory completed the current access this cycle
//   PCWrite       PC register enable
//   AdrSrc        memory address select: 0 = PC, 1 = Result
//   MemWrite      memory write strobe
//   IRWrite       instruction / OldPC register enable
//   ResultSrc     00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA       00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB       00 rs2, 01 ImmExt, 10 constant 4
//   ImmSrc        000 I, 001 S, 010 B, 011 J, 100 U
//   RegWrite      register file write enable
//   ALUControl    000 add, 001 sub, 010 and, 011 or, 101 slt
//   IllegalInstr  one-cycle pulse on an unsupported opcode
//   State         current state, for debug
//   InstRet       retired-instruction count (wraps)
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [2:0]           ALUControl,
  output logic                 IllegalInstr,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] InstRet
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   instret_q, instret_d;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic       retire;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, alu_dec, imm_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // ALU function for R/I-type execute states; sub only exists for R-type,
  // since funct7b5 is an immediate bit for addi.
  always_comb begin
    alu_dec = 3'b000;
    case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECUTER && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    retire      = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = MemReady;
        pc_write   = MemReady;
        state_d    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here and captured into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = MemReady;
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = Zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire};
  end

  // Write enables are masked by reset so nothing is written while held in
  // reset, even though FETCH would otherwise follow MemReady.
  assign PCWrite      = pc_write  & reset;
  assign IRWrite      = ir_write  & reset;
  assign RegWrite     = reg_write & reset;
  assign MemWrite     = mem_write & reset;
  assign IllegalInstr = illegal   & reset;
  assign AdrSrc       = adr_src;
  assign ResultSrc    = result_src;
  assign ALUSrcA      = alu_src_a;
  assign ALUSrcB      = alu_src_b;
  assign ImmSrc       = imm_src;
  assign ALUControl   = alu_control;
  assign State        = state_q;
  assign InstRet      = instret_q;

endmodule
